// File: rtl/rr_grant_ctrl.sv
// -----------------------------------------------------------------------------
// rr_grant_ctrl
//
// Round-robin arbiter / sequencer for a shared resource with up to N
// requesters. It samples the request vector in IDLE and grants a single owner.
// The grant is held until one of these happens:
//   - the owner releases it (rel), or
//   - the owner drops its request, or
//   - the arbiter is disabled (en_n = 1), or
//   - MAX_HOLD cycles have elapsed, which forces release and pulses timeout.
//
// Every grant is followed by one GAP cycle, so that two owners never overlap.
// Priority rotates: the most recent owner ranks lowest in the next
// arbitration round.
//
// Ports
//   clk       in   1    rising-edge clock
//   rst_n     in   1    asynchronous reset, active-low
//   en_n      in   1    arbiter enable, active-low (1 = no grants issued)
//   req       in   N    request vector, bit i = requester i wants the resource
//   rel       in   1    owner release strobe, sampled while a grant is active
//   grant     out  N    one-hot grant (registered), zero when there is no owner
//   grant_id  out  IDW  binary index of the owner, 0 when grant is zero
//   busy      out  1    1 while a grant is active (equals |grant)
//   timeout   out  1    single-cycle pulse when a grant is forcibly revoked
// -----------------------------------------------------------------------------
module rr_grant_ctrl #(
    parameter int N        = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_n,
    input  logic [N-1:0]   req,
    input  logic           rel,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           timeout
);

    // Hold counter only has to reach MAX_HOLD; it is never allowed to wrap.
    localparam int HCW = $clog2(MAX_HOLD + 1);

    localparam logic [N-1:0]   GRANT_NONE = {N{1'b0}};
    localparam logic [IDW-1:0] ID_ZERO    = {IDW{1'b0}};
    localparam logic [IDW-1:0] ID_LAST    = IDW'(N - 1);
    localparam logic [HCW-1:0] HOLD_ZERO  = {HCW{1'b0}};
    localparam logic [HCW-1:0] HOLD_ONE   = HCW'(1);
    localparam logic [HCW-1:0] HOLD_MAX   = HCW'(MAX_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } state_e;

    // Expand a requester index into its one-hot grant vector.
    function automatic logic [N-1:0] onehot_of(input logic [IDW-1:0] id);
        logic [N-1:0] v;
        v = GRANT_NONE;
        for (int i = 0; i < N; i++) begin
            v[i] = (id == IDW'(i));
        end
        return v;
    endfunction

    // Round-robin pick. Candidates are scanned starting one past the previous
    // owner and wrapping modulo N. The result is {found, index}. The loop walks
    // from lowest to highest priority, so the last match it sees is the
    // highest-priority request.
    function automatic logic [IDW:0] pick_winner(input logic [N-1:0]   r,
                                                 input logic [IDW-1:0] last);
        logic [IDW:0]   res;
        logic [IDW-1:0] idx;
        res = {1'b0, ID_ZERO};
        for (int k = N; k >= 1; k--) begin
            idx = IDW'((int'(last) + k) % N);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    state_e         state_q,    state_d;
    logic [N-1:0]   grant_q,    grant_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic           busy_q,     busy_d;
    logic           timeout_q,  timeout_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic [IDW-1:0] last_id_q,  last_id_d;

    logic [IDW:0]   pick_s;
    logic           win_valid_s;
    logic [IDW-1:0] win_id_s;
    logic           owner_req_s;

    // Arbitration result for the current cycle and the current owner's request.
    always_comb begin
        pick_s      = pick_winner(req, last_id_q);
        win_valid_s = pick_s[IDW];
        win_id_s    = pick_s[IDW-1:0];
        owner_req_s = req[grant_id_q];
    end

    // Next-state and next-output logic for the IDLE / GRANT / GAP sequence.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        last_id_d  = last_id_q;
        case (state_q)
            ST_IDLE: begin
                if (!en_n && win_valid_s) begin
                    state_d    = ST_GRANT;
                    grant_d    = onehot_of(win_id_s);
                    grant_id_d = win_id_s;
                    busy_d     = 1'b1;
                    hold_cnt_d = HOLD_ONE;
                    last_id_d  = win_id_s;
                end else begin
                    state_d    = ST_IDLE;
                    grant_d    = GRANT_NONE;
                    grant_id_d = ID_ZERO;
                    busy_d     = 1'b0;
                    hold_cnt_d = HOLD_ZERO;
                end
            end
            ST_GRANT: begin
                // Checked in priority order: disable, voluntary release, forced release.
                if (en_n || rel || !owner_req_s || (hold_cnt_q == HOLD_MAX)) begin
                    state_d    = ST_GAP;
                    grant_d    = GRANT_NONE;
                    grant_id_d = ID_ZERO;
                    busy_d     = 1'b0;
                    hold_cnt_d = HOLD_ZERO;
                    // Only a pure MAX_HOLD expiry counts as a timeout.
                    if (!en_n && !rel && owner_req_s) begin
                        timeout_d = 1'b1;
                    end else begin
                        timeout_d = 1'b0;
                    end
                end else begin
                    state_d    = ST_GRANT;
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            ST_GAP: begin
                // One dead cycle; requests are deliberately not sampled here.
                state_d    = ST_IDLE;
                grant_d    = GRANT_NONE;
                grant_id_d = ID_ZERO;
                busy_d     = 1'b0;
                hold_cnt_d = HOLD_ZERO;
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = GRANT_NONE;
                grant_id_d = ID_ZERO;
                busy_d     = 1'b0;
                hold_cnt_d = HOLD_ZERO;
                last_id_d  = ID_LAST;
            end
        endcase
    end

    // State and registered outputs. Reset makes requester 0 the top priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= GRANT_NONE;
            grant_id_q <= ID_ZERO;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= HOLD_ZERO;
            last_id_q  <= ID_LAST;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
            last_id_q  <= last_id_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rr_grant_ctrl
//
// Directed scenarios with fixed expected values, followed by a randomized run
// that is compared against a cycle-level reference model of the arbiter.
// -----------------------------------------------------------------------------
module tb_rr_grant_ctrl;

    localparam int N        = 8;
    localparam int IDW      = 3;
    localparam int MAX_HOLD = 16;

    logic           clk;
    logic           rst_n;
    logic           en_n;
    logic [N-1:0]   req;
    logic           rel;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           timeout;

    int total;
    int bad;

    // Reference model state: who owns the resource, and the rotation pointer.
    int m_owner;   // -1 means no owner
    int m_last;
    int m_hold;
    bit m_gap;
    bit m_to;

    rr_grant_ctrl #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_n     (en_n),
        .req      (req),
        .rel      (rel),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_hold  = 0;
        m_gap   = 1'b0;
        m_to    = 1'b0;
    endtask

    // One clock edge of the arbiter's rules, applied to the current inputs.
    task automatic model_step();
        bit found;
        int c;
        m_to = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (m_owner >= 0) begin
            if (en_n == 1'b1 || rel == 1'b1 || req[m_owner] == 1'b0) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (m_hold == MAX_HOLD) begin
                m_owner = -1;
                m_gap   = 1'b1;
                m_to    = 1'b1;
            end else begin
                m_hold = m_hold + 1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (en_n == 1'b0 && req != 8'h00) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && req[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_last  = c;
                    m_hold  = 1;
                end
            end
        end
    endtask

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] one;
        one = 8'h01;
        if (m_owner >= 0) return one << m_owner;
        return 8'h00;
    endfunction

    // Advance one clock, update the model, and settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en_n  = 1'b0;
        req   = 8'h00;
        rel   = 1'b0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en_n  = 1'b0;
        req   = 8'h00;
        rel   = 1'b0;
        model_reset();
        step();
        total++;
        if (grant !== 8'h00 || busy !== 1'b0 || grant_id !== 3'd0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: grant=%h busy=%b id=%0d to=%b required all zero",
                     grant, busy, grant_id, timeout);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (grant !== 8'h00 || busy !== 1'b0 || grant_id !== 3'd0) begin
                bad++;
                $display("FAIL reset_idle cyc%0d: grant=%h busy=%b id=%0d required zero",
                         i, grant, busy, grant_id);
            end
        end
    endtask

    task automatic test_two_req();
        do_reset();
        req = 8'h81;
        step();
        total++;
        if (grant !== 8'h01 || grant_id !== 3'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL two_req_first: grant=%h id=%0d busy=%b required 01/0/1",
                     grant, grant_id, busy);
        end
        rel = 1'b1;
        step();
        rel = 1'b0;
        total++;
        if (grant !== 8'h00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL two_req_gap1: grant=%h busy=%b required 00/0", grant, busy);
        end
        step();
        total++;
        if (grant !== 8'h00) begin
            bad++;
            $display("FAIL two_req_gap2: grant=%h required 00", grant);
        end
        step();
        total++;
        if (grant !== 8'h80 || grant_id !== 3'd7) begin
            bad++;
            $display("FAIL two_req_second: grant=%h id=%0d required 80/7", grant, grant_id);
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] one;
        one = 8'h01;
        do_reset();
        req = 8'hFF;
        step();
        for (int i = 0; i <= N; i++) begin
            total++;
            if (grant_id !== IDW'(i % N) || grant !== (one << (i % N))) begin
                bad++;
                $display("FAIL rotation step%0d: id=%0d grant=%h required id=%0d",
                         i, grant_id, grant, i % N);
            end
            rel = 1'b1;
            step();
            rel = 1'b0;
            total++;
            if (grant !== 8'h00) begin
                bad++;
                $display("FAIL rotation_gap step%0d: grant=%h required 00", i, grant);
            end
            step();
            step();
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 8'h04;
        step();
        for (int c = 1; c <= MAX_HOLD; c++) begin
            total++;
            if (grant !== 8'h04 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL timeout_hold cyc%0d: grant=%h to=%b required 04/0",
                         c, grant, timeout);
            end
            step();
        end
        total++;
        if (grant !== 8'h00 || timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_pulse: grant=%h to=%b required 00/1", grant, timeout);
        end
        step();
        total++;
        if (grant !== 8'h00 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_after: grant=%h to=%b required 00/0", grant, timeout);
        end
        step();
        total++;
        if (grant !== 8'h04 || grant_id !== 3'd2 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_regrant: grant=%h id=%0d required 04/2", grant, grant_id);
        end
    endtask

    task automatic test_enable();
        do_reset();
        req = 8'h08;
        step();
        total++;
        if (grant_id !== 3'd3 || grant !== 8'h08) begin
            bad++;
            $display("FAIL enable_grant: id=%0d grant=%h required 3/08", grant_id, grant);
        end
        en_n = 1'b1;
        step();
        total++;
        if (grant !== 8'h00 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL enable_drop: grant=%h to=%b required 00/0", grant, timeout);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (grant !== 8'h00 || busy !== 1'b0) begin
                bad++;
                $display("FAIL enable_off cyc%0d: grant=%h busy=%b required 00/0",
                         i, grant, busy);
            end
        end
        en_n = 1'b0;
        step();
        total++;
        if (grant !== 8'h08) begin
            bad++;
            $display("FAIL enable_resume: grant=%h required 08", grant);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h20;
        step();
        total++;
        if (grant_id !== 3'd5) begin
            bad++;
            $display("FAIL areset_owner: id=%0d required 5", grant_id);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (grant !== 8'h00 || busy !== 1'b0 || grant_id !== 3'd0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL areset_clear: grant=%h busy=%b id=%0d required zero",
                     grant, busy, grant_id);
        end
        step();
        rst_n = 1'b1;
        req   = 8'h21;
        step();
        total++;
        if (grant_id !== 3'd0 || grant !== 8'h01) begin
            bad++;
            $display("FAIL areset_ptr: id=%0d grant=%h required 0/01", grant_id, grant);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] eg;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) req = N'($urandom);
            rel  = ($urandom_range(0, 19) == 0);
            en_n = ($urandom_range(0, 39) == 0);
            step();
            eg = exp_grant();
            total++;
            if (grant !== eg || busy !== (m_owner >= 0) || timeout !== m_to ||
                grant_id !== IDW'((m_owner >= 0) ? m_owner : 0)) begin
                bad++;
                $display("FAIL random cyc%0d: grant=%h id=%0d busy=%b to=%b required grant=%h owner=%0d to=%b",
                         i, grant, grant_id, busy, timeout, eg, m_owner, m_to);
            end
        end
        rel  = 1'b0;
        en_n = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en_n  = 1'b0;
        req   = 8'h00;
        rel   = 1'b0;
        model_reset();
        test_reset();
        test_two_req();
        test_rotation();
        test_timeout();
        test_enable();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
